// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and the baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } t_uart_state;

    // System clocks per serial bit.
    function automatic int clk_div(input int sys_freq, input int baud_freq);
        return sys_freq / baud_freq;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word handshake bundle: the receiver is the master, the consumer the slave.
interface uart_rx_if #(
    parameter int DW = 8
);
    logic          rx_ready;
    logic [DW-1:0] rx_par;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_overrun;

    modport master (
        output rx_par,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_par,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture; both stages preset to the line's idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DW data bits LSB first, 1 stop bit, mid-bit sampling,
// valid/ready output with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DW        = 8,
    parameter int SYS_FREQ  = 100000000,
    parameter int BAUD_FREQ = 9600
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_ser,
    uart_rx_if.master rx_bus
);
    localparam int CLK_DIVISOR = clk_div(SYS_FREQ, BAUD_FREQ);
    localparam int HALF_DIV    = CLK_DIVISOR / 2;
    localparam int CW          = $clog2(CLK_DIVISOR);
    localparam int BW          = $clog2(DW);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIVISOR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    logic          rx_s;
    logic          rx_d_r;
    logic          start_edge_s;

    t_uart_state   state_r,     state_s;
    logic [CW-1:0] clk_cnt_r,   clk_cnt_s;
    logic [BW-1:0] bit_cnt_r,   bit_cnt_s;
    logic [DW-1:0] shift_r,     shift_s;
    logic [DW-1:0] rx_par_r,    rx_par_s;
    logic          rx_valid_r,  rx_valid_s;
    logic          frame_err_r, frame_err_s;
    logic          overrun_r,   overrun_s;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_ser),
        .q   (rx_s)
    );

    assign start_edge_s = rx_d_r & ~rx_s;

    // Delayed copy of the synchronised line for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d_r <= 1'b1;
        end else begin
            rx_d_r <= rx_s;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            clk_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            rx_par_r    <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            clk_cnt_r   <= clk_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            rx_par_r    <= rx_par_s;
            rx_valid_r  <= rx_valid_s;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
        end
    end

    // Next-state, bit timing and word delivery decisions.
    always_comb begin
        state_s     = state_r;
        clk_cnt_s   = clk_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        rx_par_s    = rx_par_r;
        rx_valid_s  = rx_valid_r;
        frame_err_s = 1'b0;
        overrun_s   = 1'b0;

        // A consumed word clears valid; a frame completing this cycle may reload it below.
        if (rx_valid_r && rx_bus.rx_ready) begin
            rx_valid_s = 1'b0;
        end else begin
            rx_valid_s = rx_valid_r;
        end

        case (state_r)
            IDLE: begin
                if (start_edge_s) begin
                    state_s   = START;
                    clk_cnt_s = '0;
                end else begin
                    state_s   = IDLE;
                end
            end
            START: begin
                if (clk_cnt_r == CNT_HALF) begin
                    clk_cnt_s = '0;
                    bit_cnt_s = '0;
                    if (!rx_s) begin
                        state_s = DATA;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_s = IDLE;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt_r == CNT_FULL) begin
                    shift_s   = {rx_s, shift_r[DW-1:1]};
                    clk_cnt_s = '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = '0;
                        state_s   = STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt_r == CNT_FULL) begin
                    clk_cnt_s = '0;
                    state_s   = IDLE;
                    if (!rx_s) begin
                        frame_err_s = 1'b1;
                    end else if (!rx_valid_r || rx_bus.rx_ready) begin
                        rx_par_s   = shift_r;
                        rx_valid_s = 1'b1;
                    end else begin
                        overrun_s = 1'b1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CW'(1);
                end
            end
            default: begin
                state_s   = IDLE;
                clk_cnt_s = '0;
                bit_cnt_s = '0;
            end
        endcase
    end

    assign rx_bus.rx_par       = rx_par_r;
    assign rx_bus.rx_valid     = rx_valid_r;
    assign rx_bus.rx_frame_err = frame_err_r;
    assign rx_bus.rx_overrun   = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a bit-level line driver, a frame-level outcome model
// feeding expectation queues, and an independent monitor that checks every output event.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DIV = 16;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_ser = 1'b1;

    uart_rx_if #(.DW(DW)) bus ();

    uart_rx #(.DW(DW), .SYS_FREQ(16), .BAUD_FREQ(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_ser (rx_ser),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expectations
    logic [DW-1:0] word_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    bit held     = 1'b0;   // model: a delivered word is sitting unconsumed
    bit mon_en   = 1'b0;

    int frame_start_cyc = 0;
    int valid_rise_cyc  = -1;

    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_par   = '0;
    logic          prev_ferr  = 1'b0;
    logic          prev_ovr   = 1'b0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output event is matched against the expectation queues.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.rx_valid && !prev_valid) valid_rise_cyc = cyc;
            if (bus.rx_valid && bus.rx_ready) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word", bus.rx_par, 0);
                    check("unexpected_word_present", 1, 0);
                end else begin
                    check("word", bus.rx_par, word_q.pop_front());
                end
            end
            if (prev_valid && !prev_ready && bus.rx_valid)
                check("par_stable", bus.rx_par, prev_par);
            if (bus.rx_frame_err) begin
                check("frame_err_expected", (exp_ferr > 0), 1);
                if (exp_ferr > 0) exp_ferr--;
                check("frame_err_1clk", prev_ferr, 0);
            end
            if (bus.rx_overrun) begin
                check("overrun_expected", (exp_ovr > 0), 1);
                if (exp_ovr > 0) exp_ovr--;
                check("overrun_1clk", prev_ovr, 0);
            end
        end
        prev_valid <= bus.rx_valid;
        prev_ready <= bus.rx_ready;
        prev_par   <= bus.rx_par;
        prev_ferr  <= bus.rx_frame_err;
        prev_ovr   <= bus.rx_overrun;
    end

    task automatic idle(input int n);
        rx_ser = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_bit(input logic v);
        rx_ser = v;
        repeat (DIV) begin @(posedge clk); #1; end
    endtask

    // Frame-level model: decides the outcome from the stop bit and whether a word is held.
    task automatic expect_frame(input logic [DW-1:0] d, input logic stop);
        if (!stop) exp_ferr++;
        else if (held) exp_ovr++;
        else begin
            word_q.push_back(d);
            if (!bus.rx_ready) held = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int gap);
        expect_frame(d, stop);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int b = 0; b < DW; b++) drive_bit(d[b]);
        drive_bit(stop);
        idle(gap);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          rs;
        int            gap;

        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_valid", bus.rx_valid, 0);
        check("rst_par", bus.rx_par, 0);
        check("rst_ferr", bus.rx_frame_err, 0);
        check("rst_ovr", bus.rx_overrun, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(10);

        // Single frame with latency measurement from the start edge
        valid_rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 20);
        check("latency_ok", ((valid_rise_cyc - frame_start_cyc) >= 155 &&
                             (valid_rise_cyc - frame_start_cyc) <= 157), 1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 20);

        // False start: line low for 5 clocks
        rx_ser = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        idle(20);
        check("false_start_idle", dut.state_r, IDLE);

        // Framing error followed by a good frame
        send_frame(8'h3C, 1'b0, 20);
        send_frame(8'h42, 1'b1, 20);

        // Overrun: consumer stalled across two frames
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 20);
        check("ovr_valid_held", bus.rx_valid, 1);
        check("ovr_par_held", bus.rx_par, 8'h11);
        bus.rx_ready = 1'b1;
        held = 1'b0;
        idle(3);
        check("ovr_valid_drop", bus.rx_valid, 0);

        // Reset during bit 3 of 0x5A abandons the frame
        drive_bit(1'b0);
        for (int b = 0; b < 3; b++) drive_bit(rd_5a(b));
        rx_ser = 1'b1;
        repeat (DIV / 2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", bus.rx_valid, 0);
        check("mid_rst_par", bus.rx_par, 0);
        check("mid_rst_ferr", bus.rx_frame_err, 0);
        check("mid_rst_ovr", bus.rx_overrun, 0);
        check("mid_rst_state", dut.state_r, IDLE);
        idle(8 * DIV);
        send_frame(8'h81, 1'b1, 20);

        // Randomised frames, consumer always ready
        for (int i = 0; i < 25; i++) begin
            rd  = DW'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 24);
            if (!rs && gap < 4) gap = 4;
            send_frame(rd, rs, gap);
        end

        idle(3 * DIV);
        check("words_outstanding", word_q.size(), 0);
        check("ferr_outstanding", exp_ferr, 0);
        check("ovr_outstanding", exp_ovr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic rd_5a(input int b);
        logic [7:0] v;
        v = 8'h5A;
        return v[b];
    endfunction
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver and the counterpart of the team's UART transmitter. Frame format is 1 start bit, DW data bits LSB first, 1 stop bit, no parity, at a fixed divided baud rate. The block synchronises the asynchronous serial line, samples each bit at mid-bit, and presents each received word on a valid/ready handshake. It reports framing errors and overruns.

Parameters:
DW, 8, data bits per frame (>=2)
SYS_FREQ, 100000000, system clock frequency in Hz
BAUD_FREQ, 9600, baud rate in Hz; CLK_DIVISOR = SYS_FREQ/BAUD_FREQ (>=4), HALF_DIV = CLK_DIVISOR/2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_ser  in  1  asynchronous serial line, idle high
rx_ready  in  1  consumer accepts rx_par this cycle
rx_par  out  DW  received word, stable while rx_valid is high
rx_valid  out  1  rx_par holds an unconsumed word
rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
rx_overrun  out  1  one-cycle pulse: completed frame dropped because rx_valid was still held

Behaviour:
- Reset values: rx_par=0, rx_valid=0, rx_frame_err=0, rx_overrun=0. Synchroniser flops reset to 1, state=IDLE, counters=0. Reset mid-frame abandons the frame; nothing is reported.
- rx_ser passes through a 2-flop synchroniser to give rx_s. A registered copy, rx_d, is used for falling-edge detection: start_edge = rx_d & ~rx_s.
- State machine: IDLE, START, DATA, STOP (2-bit enum).
- IDLE: on start_edge, go to START with clk_cnt=0. A line held low, such as a break, does not retrigger because an edge is required.
- START: clk_cnt counts up. At clk_cnt==HALF_DIV-1, sample rx_s:
  - If 0: go to DATA with clk_cnt=0 and bit_cnt=0.
  - If 1: false start (glitch); return to IDLE with no outputs.
- DATA: at clk_cnt==CLK_DIVISOR-1, sample rx_s into the shift register MSB and shift right, so the LSB is received first. Then clk_cnt=0 and bit_cnt increments. After the sample with bit_cnt==DW-1, go to STOP. Otherwise clk_cnt increments.
- STOP: at clk_cnt==CLK_DIVISOR-1, sample rx_s and return to IDLE. This is mid stop-bit, so the next start edge can be caught.
  - rx_s==1 (good frame) and (rx_valid==0 or rx_ready==1): next cycle rx_par=shift register and rx_valid=1.
  - rx_s==1, rx_valid==1 and rx_ready==0: the new word is dropped. rx_overrun pulses for 1 cycle. The old rx_par is preserved.
  - rx_s==0: the word is discarded and rx_frame_err pulses for 1 cycle. rx_valid and rx_par are unchanged.
- Handshake: rx_valid&rx_ready consumes the word, and rx_valid=0 next cycle unless a good frame completes in the same cycle. In that case the new word loads and rx_valid stays 1, with no overrun.
- rx_par does not change while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises 1 clk after the stop-bit sample. Measured from the line's start falling edge, this is 2 (sync) + 1 (edge) + HALF_DIV + (DW+1)*CLK_DIVISOR + 1 clocks, within ±1.
- Widths: clk_cnt is $clog2(CLK_DIVISOR) bits and bit_cnt is $clog2(DW) bits. Counters wrap to 0 only by explicit assignment; they never overflow.

Decomposition:
- Shared package uart_pkg: t_uart_state enum {IDLE,START,DATA,STOP}, shared by TX and RX, plus a divisor function clk_div(SYS_FREQ,BAUD_FREQ).
- Sub-module uart_sync: a 2-flop synchroniser with parameterised reset value 1, reusable for other async inputs.

Test Plan:
Run with SYS_FREQ=16, BAUD_FREQ=1 (CLK_DIVISOR=16) and DW=8; the line is driven by a bit-accurate model.
- Single frame 0xA5 with rx_ready=1 -> one rx_valid pulse with rx_par=0xA5 and no error pulses.
- Back-to-back frames 0x00 then 0xFF with no idle gap, rx_ready held 1 -> two words 0x00, 0xFF in order.
- rx_ser low for 5 clocks then high -> false start, no rx_valid, no error, state returns to IDLE.
- Frame 0x3C with the stop bit driven 0 -> rx_frame_err pulses exactly 1 clk and rx_valid stays 0. A following valid frame 0x42 is received correctly.
- rx_ready=0; send 0x11 then 0x22 -> rx_par=0x11 with rx_valid held 1, rx_overrun pulses once at the second stop sample. Raising rx_ready then yields 0x11 and rx_valid drops.
- Assert rst for 1 clk during bit 3 of 0x5A -> all outputs 0 and no word delivered. A following frame 0x81 is received correctly.
